// File: rtl/clk_div_pkg.sv
// Shared constants and clamp helpers for the clock-enable divider bank.
// clamp_hi exists only when CLK_DIV_BANK_DUTY_EN is defined.
package clk_div_pkg;

   localparam int unsigned MIN_DIV = 2;
   localparam int          DEF_CW  = 27;
   localparam int unsigned DEF_DIV = 100_000_000;

   // Truncate to the counter width first so the clamp sees what will be stored.
   function automatic logic [31:0] clamp_div(input logic [31:0] value, input int width);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      v    = value & mask;
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

`ifdef CLK_DIV_BANK_DUTY_EN
   function automatic logic [31:0] clamp_hi(input logic [31:0] hi, input logic [31:0] div);
      if (hi < 32'd1)
         return 32'd1;
      else if (hi > div - 32'd1)
         return div - 32'd1;
      else
         return hi;
   endfunction
`endif

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, registered slow_clk and tick.
// Pending divisor (and high time under CLK_DIV_BANK_DUTY_EN) swaps in only at wrap, or next clock when disabled.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int          CW          = DEF_CW,
   parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          wr,
   input  logic [CW-1:0] wr_div,
`ifdef CLK_DIV_BANK_DUTY_EN
   input  logic [CW-1:0] wr_hi,
`endif
   output logic          pend,
   output logic          slow_clk,
   output logic          tick
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] div;
   logic [CW-1:0] pend_div;
   logic [CW-1:0] hi;
   logic          wrap;

   assign wrap = (cnt == div - CW'(1));

`ifdef CLK_DIV_BANK_DUTY_EN
   logic [CW-1:0] pend_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi      <= CW'(DEFAULT_DIV >> 1);
         pend_hi <= '0;
      end else begin
         if (pend && (!en || wrap))
            hi <= pend_hi;
         if (wr)
            pend_hi <= CW'(clamp_hi(32'(wr_hi), clamp_div(32'(wr_div), CW)));
      end
   end
`else
   assign hi = div >> 1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div      <= CW'(DEFAULT_DIV);
         pend_div <= '0;
         pend     <= 1'b0;
         slow_clk <= 1'b0;
         tick     <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (en) begin
            tick     <= wrap;
            slow_clk <= (cnt < hi);
            if (wrap) begin
               cnt <= '0;
               if (pend) begin
                  div  <= pend_div;
                  pend <= 1'b0;
               end
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (pend) begin
            // Idle channel: take the new divisor now and restart the period.
            cnt  <= '0;
            div  <= pend_div;
            pend <= 1'b0;
         end
         // wr is only raised while pend is clear, so it never races the apply above.
         if (wr) begin
            pend     <= 1'b1;
            pend_div <= CW'(clamp_div(32'(wr_div), CW));
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// NCH-channel programmable clock-enable generator with a valid/ready divisor write port.
// Optional per-channel duty (cfg_hi) when CLK_DIV_BANK_DUTY_EN is defined.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int          NCH         = 4,
   parameter int          CW          = DEF_CW,
   parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NCH-1:0]                        en,
   input  logic                                  cfg_valid,
   output logic                                  cfg_ready,
   input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_ch,
   input  logic [CW-1:0]                         cfg_div,
`ifdef CLK_DIV_BANK_DUTY_EN
   input  logic [CW-1:0]                         cfg_hi,
`endif
   output logic [NCH-1:0]                        slow_clk,
   output logic [NCH-1:0]                        tick
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] pend;
   logic [NCH-1:0] wr;

   // Unmatched channel numbers leave ready high and no strobe, so the write is dropped.
   always_comb begin
      cfg_ready = 1'b1;
      wr        = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CHW'(i)) begin
            cfg_ready = !pend[i];
            wr[i]     = cfg_valid && !pend[i];
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_div_chan #(
         .CW          (CW),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[i]),
         .wr       (wr[i]),
         .wr_div   (cfg_div),
`ifdef CLK_DIV_BANK_DUTY_EN
         .wr_hi    (cfg_hi),
`endif
         .pend     (pend[i]),
         .slow_clk (slow_clk[i]),
         .tick     (tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with NCH=4, CW=8, DEFAULT_DIV=10.
module tb_clk_div_bank;

   logic       clk;
   logic       rst_n;
   logic [3:0] en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] slow_clk;
   logic [3:0] tick;

   int checks   = 0;
   int failures = 0;

`ifdef CLK_DIV_BANK_DUTY_EN
   logic [7:0] cfg_hi;
   logic       duty_ovr = 1'b0;
   logic [7:0] hi_val   = '0;
   assign cfg_hi = duty_ovr ? hi_val : (cfg_div >> 1);
`endif

   clk_div_bank #(.NCH(4), .CW(8), .DEFAULT_DIV(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
`ifdef CLK_DIV_BANK_DUTY_EN
      .cfg_hi    (cfg_hi),
`endif
      .slow_clk  (slow_clk),
      .tick      (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One char per clock: slow/tick patterns for channel ch; quiet channels must stay 0.
   task automatic run(input int ch, input string s, input string t, input logic [3:0] quiet);
      for (int i = 0; i < s.len(); i++) begin
         @(posedge clk); #1;
         chk($sformatf("slow_clk%0d step%0d", ch, i), 32'(slow_clk[ch]), 32'(s[i] == "1"));
         chk($sformatf("tick%0d step%0d", ch, i), 32'(tick[ch]), 32'(t[i] == "1"));
         chk($sformatf("quiet step%0d", i), 32'((slow_clk | tick) & quiet), 32'd0);
      end
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      #1;
      chk(tag, 32'(cfg_ready), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      #1;
      chk("reset slow_clk", 32'(slow_clk), 32'd0);
      chk("reset tick", 32'(tick), 32'd0);
      chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; en = 4'b0001;

      // Default divisor 10: 5 high / 5 low, tick on the wrap.
      run(0, "11111000001111100000", "00000000010000000001", 4'b1110);
      run(0, "111", "000", 4'b1110);

      // Mid-period write of div=3 to ch0 at cnt=3.
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
      chk_ready("ready before write", 1'b1);
      run(0, "1", "0", 4'b1110);
      cfg_valid = 1'b0; cfg_ch = 2'd1;
      chk_ready("ch1 ready independent", 1'b1);
      cfg_ch = 2'd0;
      chk_ready("ch0 ready while pending", 1'b0);
      run(0, "10000", "00000", 4'b1110);
      chk_ready("ch0 ready before wrap", 1'b0);
      run(0, "0", "1", 4'b1110);
      chk_ready("ch0 ready after apply", 1'b1);
      run(0, "100100100", "001001001", 4'b1110);

      // Second write held while pending: div=6 then div=4.
      cfg_valid = 1'b1; cfg_div = 8'd6;
      chk_ready("ready first of two", 1'b1);
      run(0, "1", "0", 4'b1110);
      cfg_div = 8'd4;
      chk_ready("second write stalled", 1'b0);
      run(0, "0", "0", 4'b1110);
      chk_ready("second write still stalled", 1'b0);
      run(0, "0", "1", 4'b1110);
      chk_ready("second write ready after apply", 1'b1);
      run(0, "1", "0", 4'b1110);
      cfg_valid = 1'b0;
      chk_ready("second write pending", 1'b0);
      run(0, "11000", "00001", 4'b1110);
      chk_ready("second write applied", 1'b1);
      run(0, "11001100", "00010001", 4'b1110);

      // div=0 to running ch2 is clamped to 2.
      en = 4'b0101; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
      chk_ready("ch2 ready", 1'b1);
      run(2, "1", "0", 4'b1010);
      cfg_valid = 1'b0;
      chk_ready("ch2 pending", 1'b0);
      run(2, "111100000", "000000001", 4'b1010);
      chk_ready("ch2 applied", 1'b1);
      run(2, "101010", "010101", 4'b1010);

      // Asynchronous reset mid-count.
      #3; rst_n = 1'b0; en = '0;
      #1;
      chk("async reset slow_clk", 32'(slow_clk), 32'd0);
      chk("async reset tick", 32'(tick), 32'd0);
      chk("async reset ready", 32'(cfg_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; en = 4'b0001;

      // Pause at cnt=4 for 7 cycles, then resume; period shows div back at 10.
      run(0, "1111", "0000", 4'b1110);
      en = 4'b0000;
      run(0, "1111111", "0000000", 4'b1110);
      en = 4'b0001;
      run(0, "100000", "000001", 4'b1110);
      run(0, "1111100000", "0000000001", 4'b1110);

      // Write while disabled applies on the next clock.
      en = 4'b0000; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
      run(0, "0", "0", 4'b1110);
      cfg_valid = 1'b0;
      chk_ready("disabled pending", 1'b0);
      run(0, "0", "0", 4'b1110);
      chk_ready("disabled applied", 1'b1);
      en = 4'b0001;
      run(0, "1010", "0101", 4'b1110);

`ifdef CLK_DIV_BANK_DUTY_EN
      duty_ovr = 1'b1;
      cfg_valid = 1'b1; cfg_div = 8'd10; hi_val = 8'd3;
      run(0, "1", "0", 4'b1110);
      cfg_valid = 1'b0;
      run(0, "0", "1", 4'b1110);
      cfg_valid = 1'b1; hi_val = 8'd0;
      run(0, "1", "0", 4'b1110);
      cfg_valid = 1'b0;
      run(0, "110000000", "000000001", 4'b1110);
      cfg_valid = 1'b1; hi_val = 8'd12;
      run(0, "1", "0", 4'b1110);
      cfg_valid = 1'b0;
      run(0, "000000000", "000000001", 4'b1110);
      run(0, "1111111110", "0000000001", 4'b1110);
      duty_ovr = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable generator: NCH independent divider channels derive slow square waves and single-cycle tick strobes from the system clock. Each channel's divisor is reprogrammed at runtime through a valid/ready write port. Updates apply glitch-free at the channel's next wrap. The block sits at the top of the design, feeding slow strobes to display scan, debounce and matrix-multiplier step logic.

## Interface
- NCH, 4: number of divider channels (1..16)
- CW, 27: counter/divisor width in bits
- DEFAULT_DIV, 100_000_000: divisor loaded into every channel at reset; must fit in CW bits
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  NCH  per-channel run enable
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_ch  in  max(1,$clog2(NCH))  target channel
- cfg_div  in  CW  new divisor
- slow_clk  out  NCH  per-channel divided square wave (registered)
- tick  out  NCH  one-cycle strobe per period (registered)

## Operation
- Per channel: cnt counts 0..div-1, then wraps to 0; advances only when en[i]=1.
- slow_clk[i] <= (cnt < hi), with hi = div>>1. High for floor(div/2) cycles and low for ceil(div/2) cycles per period.
- tick[i] <= en[i] && (cnt == div-1).
- en[i]=0: cnt and slow_clk[i] hold; tick[i] <= 0.
- Divisor clamp: cfg_div < 2 is stored as 2 (MIN_DIV).
- Write path: an accepted write stores the clamped value in pend_div[ch] and sets pend[ch].
- cfg_ready = !pend[cfg_ch], combinational on cfg_ch.
- Writes with cfg_ch >= NCH are accepted (cfg_ready=1) and dropped.
- Apply: on the cycle cnt == div-1 with en=1, div <= pend_div, cnt <= 0, pend <= 0.
- Apply when en=0: applies on the next clock, cnt <= 0, slow_clk holds.
- Accept and apply cannot coincide on one channel. pend clears at apply; cfg_ready for that channel rises the following cycle.
- Writes to different channels are independent; one write per cycle maximum.
- Reset, including mid-operation: cnt=0, div=DEFAULT_DIV, pend=0, slow_clk=0, tick=0, all immediately on rst_n low.

## Timing
- First posedge after rst_n release with en[i]=1: cnt 0->1, slow_clk[i] goes 1.
- Period is exactly div cycles. tick is high during the cycle where cnt reads 0 after a wrap.
- New divisor takes effect from the first cycle after the wrap; the old period always completes in full.
- Write-to-apply latency: at most old div cycles while running; 1 cycle while disabled.
- Every output is a flop output; no combinational path from inputs to slow_clk/tick.

## Configuration
- CLK_DIV_BANK_DUTY_EN defined:
  - Adds input cfg_hi [CW], written alongside cfg_div into pend_hi.
  - hi is per-channel stored state, applied with div.
  - Clamp hi to 1..div-1.
  - Reset hi = DEFAULT_DIV>>1.
- Undefined: cfg_hi port absent; hi = div>>1 derived combinationally; no hi storage.

## Structure
- Package clk_div_pkg holds:
  - MIN_DIV = 2
  - default CW / DEFAULT_DIV constants
  - function clamp_div(value, width)
  - function clamp_hi(hi, div) under the macro
- Sub-module clk_div_chan: one channel (cnt, div, hi, pend, pend_div, slow_clk, tick), instantiated NCH times via generate.
- Top level: cfg_ch decode, cfg_ready mux.

## Test plan
Bench parameters: NCH=4, CW=8, DEFAULT_DIV=10.
- Reset release, en=4'b0001 -> slow_clk[0] repeats 5 high / 5 low; tick[0] every 10 cycles; channels 1-3 stay 0.
- Mid-period write ch0 div=3 -> cfg_ready low until wrap; current 10-cycle period completes; then slow_clk[0] 1 high / 2 low, tick every 3.
- cfg_div=0 to ch2 (en=1) -> clamped to 2; slow_clk[2] toggles every cycle after apply; tick[2] every 2 cycles.
- Second write to ch0 while pending -> cfg_ready=0, cfg_valid held; accepted the cycle after apply; last value wins at the following wrap.
- en[0] dropped at cnt=4 for 7 cycles -> slow_clk holds, tick=0; period resumes at cnt=4. rst_n pulsed low mid-count -> all outputs 0 without a clock; div back to 10.
- DUTY_EN build: div=10, hi=3 -> 3 high / 7 low; hi=0 -> clamped to 1; hi=12 -> clamped to 9.
